fifo_downconv: RTL and testbench

Parametrised single-clock FIFO with a built-in width down-converter. It stores IN_W-bit words and presents them as a stream of OUT_W-bit slices with first-word-fall-through reads. It sits between the wide memory/transfer side (256-bit bursts) and narrow byte consumers such as the UART and pixel path. It replaces chained fixed-ratio FIFO pairs with one block that has a configurable ratio, depth and slice order, and a defined handshake.

---
 rtl/fifo_downconv_pkg.sv | 42 ++++
 rtl/fifo_downconv_ring.sv | 67 ++++++
 rtl/fifo_downconv.sv | 119 +++++++++++
 tb/tb_fifo_downconv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_downconv_pkg.sv
// Shared helpers for fifo_downconv: width arithmetic and configuration legality.
// The optional sticky error flags are enabled by defining FIFO_DOWNCONV_ERR_EN.
package fifo_downconv_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned ratio_of(input int unsigned in_w, input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

  function automatic int unsigned addr_w_of(input int unsigned depth);
    return clog2(depth);
  endfunction

  function automatic int unsigned idx_w_of(input int unsigned in_w, input int unsigned out_w);
    return clog2(ratio_of(in_w, out_w));
  endfunction

  function automatic int unsigned lvl_w_of(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  // Legal configs: whole number of slices per word, at least two of them,
  // and a power-of-two depth so the pointers wrap naturally.
  function automatic bit cfg_ok(input int unsigned in_w, input int unsigned out_w,
                                input int unsigned depth);
    if (out_w == 0) return 1'b0;
    if ((in_w % out_w) != 0) return 1'b0;
    if ((in_w / out_w) < 2) return 1'b0;
    if (depth < 2) return 1'b0;
    return ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_downconv_ring.sv
// Word storage ring for fifo_downconv: pointers, registered level/full and the array.
module fifo_downconv_ring
  import fifo_downconv_pkg::*;
#(
  parameter int unsigned W     = 256,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = addr_w_of(DEPTH),
  localparam int unsigned LVL_W  = lvl_w_of(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     wr_data,
  input  logic             wren,
  input  logic             pop,
  output logic [W-1:0]     rd_word,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              wr_acc, rd_acc;

  assign wr_acc = wren & ~full_q;
  assign rd_acc = pop & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_W'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Contents are dead once the pointers clear, so the array has no reset.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_word = mem[rd_ptr_q];
  assign full    = full_q;
  assign level   = level_q;

endmodule

// File: rtl/fifo_downconv.sv
// Single-clock FIFO storing IN_W words and emitting OUT_W slices, first-word-fall-through.
// Define FIFO_DOWNCONV_ERR_EN to add the sticky overflow/underflow flags.
module fifo_downconv
  import fifo_downconv_pkg::*;
#(
  parameter int unsigned IN_W      = 256,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned LVL_W = lvl_w_of(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  wr_data,
  input  logic             wren,
  output logic             full,
  input  logic             rden,
  output logic [OUT_W-1:0] rd_data,
  output logic             empty,
  output logic [LVL_W-1:0] level
`ifdef FIFO_DOWNCONV_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int unsigned RATIO = ratio_of(IN_W, OUT_W);
  localparam int unsigned IDX_W = idx_w_of(IN_W, OUT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (!cfg_ok(IN_W, OUT_W, DEPTH)) begin : g_bad_cfg
    $error("fifo_downconv: IN_W must be a multiple of OUT_W, ratio >= 2, DEPTH a power of 2");
  end

  logic [IN_W-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             loaded_q, loaded_d;
  logic [IN_W-1:0]  rd_word;
  logic             rd_acc, last, load;

  fifo_downconv_ring #(
    .W     (IN_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .wr_data (wr_data),
    .wren    (wren),
    .pop     (load),
    .rd_word (rd_word),
    .full    (full),
    .level   (level)
  );

  assign rd_acc = rden & loaded_q;
  assign last   = (idx_q == LAST_IDX);
  // Reloading on the last pop is what keeps word boundaries bubble-free.
  assign load   = (level != '0) & (~loaded_q | (rd_acc & last));

  always_comb begin
    sh_d     = sh_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    if (load) begin
      sh_d     = rd_word;
      idx_d    = '0;
      loaded_d = 1'b1;
    end else if (rd_acc) begin
      if (last) begin
        idx_d    = '0;
        loaded_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q     <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_data = MSB_FIRST ? sh_q[IN_W-1-i*OUT_W -: OUT_W] : sh_q[i*OUT_W +: OUT_W];
      end
    end
  end

  assign empty = ~loaded_q;

`ifdef FIFO_DOWNCONV_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wren & full) overflow_q <= 1'b1;
      if (rden & empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_downconv.sv
// Self-checking bench for fifo_downconv: MSB-first and LSB-first instances share stimulus.
module tb_fifo_downconv;

  localparam int IN_W  = 256;
  localparam int OUT_W = 8;
  localparam int DEPTH = 16;
  localparam int RATIO = IN_W / OUT_W;
  localparam int LVL_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  wr_data = '0;
  logic             wren = 1'b0;
  logic             rden = 1'b0;
  logic             full_m, empty_m, full_l, empty_l;
  logic [OUT_W-1:0] rd_m, rd_l;
  logic [LVL_W-1:0] level_m, level_l;
`ifdef FIFO_DOWNCONV_ERR_EN
  logic ovf_m, unf_m, ovf_l, unf_l;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] q_m[$];
  logic [OUT_W-1:0] q_l[$];

  typedef struct {
    logic             wren;
    logic             rden;
    logic [IN_W-1:0]  data;
    logic             accept;
    logic [LVL_W-1:0] exp_level;
    logic             exp_full;
    logic             exp_empty;
  } vec_t;
  vec_t vecs[18];

  always #5 clock = ~clock;

  fifo_downconv #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DEPTH     (DEPTH),
    .MSB_FIRST (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wren      (wren),
    .full      (full_m),
    .rden      (rden),
    .rd_data   (rd_m),
    .empty     (empty_m),
    .level     (level_m)
`ifdef FIFO_DOWNCONV_ERR_EN
    ,
    .overflow  (ovf_m),
    .underflow (unf_m)
`endif
  );

  fifo_downconv #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .DEPTH     (DEPTH),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wren      (wren),
    .full      (full_l),
    .rden      (rden),
    .rd_data   (rd_l),
    .empty     (empty_l),
    .level     (level_l)
`ifdef FIFO_DOWNCONV_ERR_EN
    ,
    .overflow  (ovf_l),
    .underflow (unf_l)
`endif
  );

  task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] byte_word(input logic [7:0] base, input logic [7:0] stride);
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) w[k*8 +: 8] = base + 8'(k) * stride;
    return w;
  endfunction

  task automatic push_word(input logic [IN_W-1:0] w);
    for (int k = 0; k < RATIO; k++) begin
      q_m.push_back(w[IN_W-1-k*OUT_W -: OUT_W]);
      q_l.push_back(w[k*OUT_W +: OUT_W]);
    end
  endtask

  // Compare any slice about to be popped, then advance one clock.
  task automatic step();
    if (rden && !empty_m) begin
      if (q_m.size() == 0) chk("sb_msb_extra", 1, 0);
      else chk("slice_msb", rd_m, q_m.pop_front());
    end
    if (rden && !empty_l) begin
      if (q_l.size() == 0) chk("sb_lsb_extra", 1, 0);
      else chk("slice_lsb", rd_l, q_l.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [IN_W-1:0] w0, wa, wb, wc;
    int gaps;

    for (int i = 0; i < 18; i++) begin
      vecs[i].wren      = 1'b1;
      vecs[i].rden      = 1'b0;
      vecs[i].data      = byte_word(8'(i * 16 + 3), 8'(2 * i + 1));
      vecs[i].accept    = (i < 17);
      vecs[i].exp_level = (i == 0) ? LVL_W'(1) : (i <= 16 ? LVL_W'(i) : LVL_W'(16));
      vecs[i].exp_full  = (i >= 16);
      vecs[i].exp_empty = (i == 0);
    end

    // Reset values, both while held and after release.
    #2;
    chk("rst_full", full_m, 0);
    chk("rst_empty", empty_m, 1);
    chk("rst_level", level_m, 0);
    chk("rst_rd_msb", rd_m, 0);
    chk("rst_rd_lsb", rd_l, 0);
`ifdef FIFO_DOWNCONV_ERR_EN
    chk("rst_ovf", ovf_m, 0);
    chk("rst_unf", unf_m, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_empty", empty_m, 1);
    chk("post_rst_level", level_m, 0);

    // Single word, write latency and full slice order for both orders.
    w0 = byte_word(8'h00, 8'h01);
    wr_data = w0;
    wren = 1'b1;
    step();
    push_word(w0);
    wren = 1'b0;
    chk("lat_level_n", level_m, 1);
    chk("lat_empty_n", empty_m, 1);
    step();
    chk("lat_empty_n1", empty_m, 0);
    chk("lat_level_n1", level_m, 0);
    chk("first_msb", rd_m, 8'h1f);
    chk("first_lsb", rd_l, 8'h00);
    rden = 1'b1;
    repeat (RATIO) step();
    rden = 1'b0;
    chk("one_word_empty", empty_m, 1);
    chk("one_word_empty_lsb", empty_l, 1);

    // Fill past capacity with no reads.
    for (int i = 0; i < 18; i++) begin
      wren    = vecs[i].wren;
      rden    = vecs[i].rden;
      wr_data = vecs[i].data;
      step();
      if (vecs[i].accept) push_word(vecs[i].data);
      chk($sformatf("fill%0d_level", i), level_m, vecs[i].exp_level);
      chk($sformatf("fill%0d_full", i), full_m, vecs[i].exp_full);
      chk($sformatf("fill%0d_empty", i), empty_m, vecs[i].exp_empty);
    end
    wren = 1'b0;
`ifdef FIFO_DOWNCONV_ERR_EN
    chk("overflow_set", ovf_m, 1);
    chk("underflow_clear", unf_m, 0);
`endif

    // Drain everything with rden held: no gaps, full drops after first reload.
    rden = 1'b1;
    gaps = 0;
    for (int s = 0; s < 17 * RATIO; s++) begin
      if (empty_m) gaps++;
      step();
      if (s == RATIO - 2) begin
        chk("pre_reload_level", level_m, 16);
        chk("pre_reload_full", full_m, 1);
      end
      if (s == RATIO - 1) begin
        chk("post_reload_level", level_m, 15);
        chk("post_reload_full", full_m, 0);
      end
    end
    rden = 1'b0;
    chk("stream_gaps", gaps, 0);
    chk("drain_empty", empty_m, 1);
    chk("drain_level", level_m, 0);
    chk("sb_after_drain", q_m.size(), 0);

    // Read while empty is ignored.
    rden = 1'b1;
    step();
    rden = 1'b0;
    chk("udf_empty", empty_m, 1);
    chk("udf_level", level_m, 0);
    chk("udf_full", full_m, 0);
`ifdef FIFO_DOWNCONV_ERR_EN
    chk("underflow_set", unf_m, 1);
`endif

    // Reset mid-word, then resume with a fresh word.
    wa = byte_word(8'h40, 8'h01);
    wb = byte_word(8'h80, 8'h03);
    wren = 1'b1;
    wr_data = wa;
    step();
    push_word(wa);
    wr_data = wb;
    step();
    push_word(wb);
    wren = 1'b0;
    rden = 1'b1;
    repeat (RATIO + 5) step();
    rden = 1'b0;
    chk("mid_b_slice_msb", rd_m, 8'h80 + 8'd26 * 8'd3);
    chk("mid_b_slice_lsb", rd_l, 8'h80 + 8'd5 * 8'd3);
    reset = 1'b1;
    #2;
    chk("mid_rst_empty", empty_m, 1);
    chk("mid_rst_level", level_m, 0);
    chk("mid_rst_full", full_m, 0);
    chk("mid_rst_rd_msb", rd_m, 0);
    chk("mid_rst_rd_lsb", rd_l, 0);
`ifdef FIFO_DOWNCONV_ERR_EN
    chk("mid_rst_ovf", ovf_m, 0);
    chk("mid_rst_unf", unf_m, 0);
`endif
    q_m.delete();
    q_l.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    wc = byte_word(8'hc5, 8'h07);
    wren = 1'b1;
    wr_data = wc;
    step();
    push_word(wc);
    wren = 1'b0;
    step();
    chk("resume_msb", rd_m, wc[IN_W-1 -: OUT_W]);
    chk("resume_lsb", rd_l, wc[OUT_W-1:0]);
    rden = 1'b1;
    repeat (RATIO) step();
    rden = 1'b0;
    chk("resume_empty", empty_m, 1);
    chk("sb_final", q_m.size() + q_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
